truth_table_exerciser: RTL and testbench

//   Sequential driver/checker for a small combinational equation block with
//   one output Y and N_IN inputs (default: 3-input A,B,C circuit).
//   On start, it walks all 2**N_IN input vectors in binary order.
//   For each vector it waits a settle time, samples the response, and

---
 rtl/truth_table_exerciser_if.sv | 28 ++
 rtl/truth_table_exerciser.sv | 131 +++++++++++++
 tb/tb_truth_table_exerciser.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/truth_table_exerciser_if.sv
// Signal bundle between the truth-table exerciser and its environment
// (the combinational block under test plus whatever launches runs).
interface truth_table_exerciser_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned NVEC = 1 << N_IN;

  logic              start;
  logic [N_IN-1:0]   drv;
  logic              resp;
  logic              busy;
  logic              done;
  logic              pass;
  logic [NVEC-1:0]   captured;
  logic [N_IN:0]     err_count;
  logic              err_valid;
  logic [N_IN-1:0]   first_err_idx;

  modport master (
    input  start, resp,
    output drv, busy, done, pass, captured, err_count, err_valid, first_err_idx
  );

  modport slave (
    output start, resp,
    input  drv, busy, done, pass, captured, err_count, err_valid, first_err_idx
  );
endinterface

// File: rtl/truth_table_exerciser.sv
// Walks every input vector of a small combinational block, samples its Y after
// a settle time and checks it against an expected truth table.
module truth_table_exerciser #(
  parameter int unsigned          N_IN     = 3,
  parameter int unsigned          SETTLE   = 4,
  parameter logic [2**N_IN-1:0]   EXPECTED = 8'hE0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  truth_table_exerciser_if.master bus
);
  localparam int unsigned NVEC = 1 << N_IN;
  localparam int unsigned WW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   drv_q, drv_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [NVEC-1:0]   captured_q, captured_d;
  logic [N_IN:0]     err_count_q, err_count_d;
  logic              err_valid_q, err_valid_d;
  logic [N_IN-1:0]   first_err_idx_q, first_err_idx_d;
  logic              mismatch_c;

  // Case-inequality so an X/Z response is flagged rather than silently matching.
  assign mismatch_c = (bus.resp !== EXPECTED[drv_q]);

  always_comb begin
    state_d         = state_q;
    drv_d           = drv_q;
    wait_cnt_d      = wait_cnt_q;
    pass_d          = pass_q;
    captured_d      = captured_q;
    err_count_d     = err_count_q;
    err_valid_d     = err_valid_q;
    first_err_idx_d = first_err_idx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          captured_d      = '0;
          err_count_d     = '0;
          err_valid_d     = 1'b0;
          first_err_idx_d = '0;
          pass_d          = 1'b0;
          drv_d           = '0;
          wait_cnt_d      = '0;
          state_d         = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (wait_cnt_q == WW'(SETTLE - 1)) begin
          state_d = S_SAMPLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_SAMPLE: begin
        captured_d[drv_q] = bus.resp;
        if (mismatch_c) begin
          err_count_d = err_count_q + (N_IN + 1)'(1);
          if (!err_valid_q) begin
            first_err_idx_d = drv_q;
            err_valid_d     = 1'b1;
          end
        end
        // Last vector: pass is decided from the count including this sample.
        if (drv_q == N_IN'(NVEC - 1)) begin
          state_d = S_DONE;
          pass_d  = (err_count_d == '0);
        end else begin
          drv_d      = drv_q + N_IN'(1);
          wait_cnt_d = '0;
          state_d    = S_SETTLE;
        end
      end
      S_DONE: begin
        drv_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      drv_q           <= '0;
      wait_cnt_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      captured_q      <= '0;
      err_count_q     <= '0;
      err_valid_q     <= 1'b0;
      first_err_idx_q <= '0;
    end else begin
      state_q         <= state_d;
      drv_q           <= drv_d;
      wait_cnt_q      <= wait_cnt_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      captured_q      <= captured_d;
      err_count_q     <= err_count_d;
      err_valid_q     <= err_valid_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign bus.drv           = drv_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.captured      = captured_q;
  assign bus.err_count     = err_count_q;
  assign bus.err_valid     = err_valid_q;
  assign bus.first_err_idx = first_err_idx_q;
endmodule

// File: tb/tb_truth_table_exerciser.sv
// Directed bench: golden, faulty and stuck-high circuits, back-to-back runs,
// mid-run reset and a SETTLE=1 instance.
module tb_truth_table_exerciser;
  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  truth_table_exerciser_if #(.N_IN(3)) bus0 ();
  truth_table_exerciser_if #(.N_IN(3)) bus1 ();

  // Circuit under exercise: 0 golden A&B|A&C, 1 faulty A&B&C, 2 Y tied high.
  always_comb begin
    case (mode)
      1:       bus0.resp = bus0.drv[2] & bus0.drv[1] & bus0.drv[0];
      2:       bus0.resp = 1'b1;
      default: bus0.resp = (bus0.drv[2] & bus0.drv[1]) | (bus0.drv[2] & bus0.drv[0]);
    endcase
  end
  assign bus1.resp = (bus1.drv[2] & bus1.drv[1]) | (bus1.drv[2] & bus1.drv[0]);

  truth_table_exerciser #(.N_IN(3), .SETTLE(4), .EXPECTED(8'hE0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  truth_table_exerciser #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hE0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on dut0 so that the next edge is edge 0.
  task automatic launch0();
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] o0, o1;
    rst_n = 1'b0; bus0.start = 1'b0; bus1.start = 1'b0; mode = 0;
    #3;
    o0 = {bus0.drv, bus0.busy, bus0.done, bus0.pass, bus0.captured,
          bus0.err_count, bus0.err_valid, bus0.first_err_idx};
    o1 = {bus1.drv, bus1.busy, bus1.done, bus1.pass, bus1.captured,
          bus1.err_count, bus1.err_valid, bus1.first_err_idx};
    checks++; if (o0 !== 22'h0) begin failures++; $display("FAIL reset_dut0 got=%h exp=000000", o0); end
    checks++; if (o1 !== 22'h0) begin failures++; $display("FAIL reset_dut1 got=%h exp=000000", o1); end
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_golden();
    mode = 0;
    launch0();
    checks++; if ({bus0.busy, bus0.drv, bus0.pass, bus0.captured, bus0.err_count} !== {1'b1, 3'd0, 1'b0, 8'h00, 4'd0}) begin
      failures++; $display("FAIL golden_start busy=%b drv=%0d pass=%b cap=%h errs=%0d exp busy=1 drv=0 pass=0 cap=00 errs=0",
                           bus0.busy, bus0.drv, bus0.pass, bus0.captured, bus0.err_count); end
    for (int e = 1; e <= 40; e++) begin
      if (e == 20) bus0.start = 1'b1;
      if (e == 21) bus0.start = 1'b0;
      step();
      if (e == 4) begin checks++; if (bus0.drv !== 3'd0) begin failures++; $display("FAIL golden_drv_e4 got=%0d exp=0", bus0.drv); end end
      if (e == 5) begin checks++; if (bus0.drv !== 3'd1) begin failures++; $display("FAIL golden_drv_e5 got=%0d exp=1", bus0.drv); end end
      if (e == 10) begin checks++; if (bus0.drv !== 3'd2) begin failures++; $display("FAIL golden_drv_e10 got=%0d exp=2", bus0.drv); end end
      if (e == 39) begin checks++; if ({bus0.busy, bus0.done} !== 2'b10) begin failures++; $display("FAIL golden_e39 busy,done got=%b exp=10", {bus0.busy, bus0.done}); end end
    end
    checks++; if ({bus0.busy, bus0.done, bus0.pass} !== 3'b111) begin failures++; $display("FAIL golden_done busy,done,pass got=%b exp=111", {bus0.busy, bus0.done, bus0.pass}); end
    checks++; if (bus0.captured !== 8'hE0) begin failures++; $display("FAIL golden_captured got=%h exp=e0", bus0.captured); end
    checks++; if ({bus0.err_count, bus0.err_valid} !== 5'b0) begin failures++; $display("FAIL golden_errs count=%0d valid=%b exp 0 0", bus0.err_count, bus0.err_valid); end
    step();
    checks++; if ({bus0.busy, bus0.done, bus0.pass, bus0.drv} !== {3'b001, 3'd0}) begin
      failures++; $display("FAIL golden_after busy=%b done=%b pass=%b drv=%0d exp 0 0 1 0", bus0.busy, bus0.done, bus0.pass, bus0.drv); end
  endtask

  task automatic test_faulty();
    mode = 1;
    launch0();
    checks++; if (bus0.pass !== 1'b0) begin failures++; $display("FAIL faulty_pass_cleared got=%b exp=0", bus0.pass); end
    for (int e = 1; e <= 40; e++) step();
    checks++; if (bus0.done !== 1'b1) begin failures++; $display("FAIL faulty_done got=%b exp=1", bus0.done); end
    checks++; if (bus0.captured !== 8'h80) begin failures++; $display("FAIL faulty_captured got=%h exp=80", bus0.captured); end
    checks++; if ({bus0.err_count, bus0.err_valid, bus0.first_err_idx, bus0.pass} !== {4'd2, 1'b1, 3'd5, 1'b0}) begin
      failures++; $display("FAIL faulty_errs count=%0d valid=%b first=%0d pass=%b exp 2 1 5 0",
                           bus0.err_count, bus0.err_valid, bus0.first_err_idx, bus0.pass); end
    // start seen while in DONE must be dropped
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    checks++; if ({bus0.busy, bus0.done} !== 2'b00) begin failures++; $display("FAIL faulty_start_in_done busy,done got=%b exp=00", {bus0.busy, bus0.done}); end
    step();
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL faulty_start_ignored busy got=%b exp=0", bus0.busy); end
  endtask

  task automatic test_tied_high();
    mode = 2;
    launch0();
    for (int e = 1; e <= 40; e++) step();
    checks++; if (bus0.captured !== 8'hFF) begin failures++; $display("FAIL tied_captured got=%h exp=ff", bus0.captured); end
    checks++; if ({bus0.err_count, bus0.err_valid, bus0.first_err_idx, bus0.pass} !== {4'd5, 1'b1, 3'd0, 1'b0}) begin
      failures++; $display("FAIL tied_errs count=%0d valid=%b first=%0d pass=%b exp 5 1 0 0",
                           bus0.err_count, bus0.err_valid, bus0.first_err_idx, bus0.pass); end
    step();
  endtask

  task automatic test_back_to_back();
    int done_edges[$];
    int busy_low;
    int got;
    busy_low = 0;
    mode = 0;
    bus0.start = 1'b1;
    step();
    for (int e = 1; e <= 124; e++) begin
      step();
      if (bus0.done) done_edges.push_back(e);
      if (!bus0.busy) busy_low++;
      if (e == 42) begin checks++; if (bus0.drv !== 3'd0) begin failures++; $display("FAIL b2b_drv_e42 got=%0d exp=0", bus0.drv); end end
      if (e == 47) begin checks++; if (bus0.drv !== 3'd1) begin failures++; $display("FAIL b2b_drv_e47 got=%0d exp=1", bus0.drv); end end
      if (e == 77) begin checks++; if (bus0.drv !== 3'd7) begin failures++; $display("FAIL b2b_drv_e77 got=%0d exp=7", bus0.drv); end end
    end
    bus0.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = (i < done_edges.size()) ? done_edges[i] : -1;
      checks++; if (got != 40 + 42 * i) begin failures++; $display("FAIL b2b_done_edge%0d got=%0d exp=%0d", i, got, 40 + 42 * i); end
    end
    checks++; if (done_edges.size() != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", done_edges.size()); end
    checks++; if (busy_low != 2) begin failures++; $display("FAIL b2b_busy_low got=%0d exp=2", busy_low); end
    step(); step();
    checks++; if (bus0.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle busy got=%b exp=0", bus0.busy); end
  endtask

  task automatic test_reset_mid();
    logic [21:0] o0;
    int done_seen;
    done_seen = 0;
    mode = 0;
    launch0();
    for (int e = 1; e <= 16; e++) step();
    checks++; if (bus0.drv !== 3'd3) begin failures++; $display("FAIL midrst_drv got=%0d exp=3", bus0.drv); end
    #2 rst_n = 1'b0;
    #1;
    o0 = {bus0.drv, bus0.busy, bus0.done, bus0.pass, bus0.captured,
          bus0.err_count, bus0.err_valid, bus0.first_err_idx};
    checks++; if (o0 !== 22'h0) begin failures++; $display("FAIL midrst_outputs got=%h exp=000000", o0); end
    for (int i = 0; i < 3; i++) begin step(); if (bus0.done) done_seen++; end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (bus0.done || bus0.busy) done_seen++; end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", done_seen); end
    test_golden();
  endtask

  task automatic test_settle1();
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 1) begin checks++; if (bus1.drv !== 3'd0) begin failures++; $display("FAIL s1_drv_e1 got=%0d exp=0", bus1.drv); end end
      if (e == 2) begin checks++; if (bus1.drv !== 3'd1) begin failures++; $display("FAIL s1_drv_e2 got=%0d exp=1", bus1.drv); end end
      if (e == 4) begin checks++; if (bus1.drv !== 3'd2) begin failures++; $display("FAIL s1_drv_e4 got=%0d exp=2", bus1.drv); end end
      if (e == 15) begin checks++; if (bus1.done !== 1'b0) begin failures++; $display("FAIL s1_done_e15 got=%b exp=0", bus1.done); end end
    end
    checks++; if ({bus1.done, bus1.pass, bus1.captured, bus1.err_count} !== {1'b1, 1'b1, 8'hE0, 4'd0}) begin
      failures++; $display("FAIL s1_done_e16 done=%b pass=%b cap=%h errs=%0d exp 1 1 e0 0",
                           bus1.done, bus1.pass, bus1.captured, bus1.err_count); end
    step();
  endtask

  initial begin
    test_reset();
    test_golden();
    test_faulty();
    test_tied_high();
    test_back_to_back();
    test_reset_mid();
    test_settle1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
